// File: rtl/led_sequencer_if.sv
// Program-entry write channel for led_sequencer: valid/ready handshake carrying one entry.
interface led_sequencer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [2:0] wr_color;
  logic [3:0] wr_bright;
  logic [7:0] wr_dwell;

  modport master (
    output wr_valid, wr_addr, wr_color, wr_bright, wr_dwell,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_color, wr_bright, wr_dwell,
    output wr_ready
  );
endinterface

// File: rtl/led_sequencer.sv
// Eight-entry RGB LED sequencer with PWM brightness and per-step dwell time.
// Define LED_SEQ_LOOP_EN to make sequences repeat until stop/rst instead of finishing once.
module led_sequencer #(
  parameter int unsigned PRESCALE   = 16,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  led_sequencer_if.slave   wr,
  input  logic [3:0]       len,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [2:0]       step,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b
);

  typedef enum logic [1:0] {StIdle, StFetch, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [3:0]          len_q, len_d;
  logic [7:0]          dwell_q, dwell_d;
  logic [PRESCALE-1:0] presc_q, presc_d;
  logic [2:0]          color_q, color_d;
  logic [3:0]          bright_q, bright_d;
  logic [3:0]          pwm_q;
  logic [2:0]          led_q;
  logic [2:0]          led_on;
  logic                tick;
  logic                last_step;

  // Program memory has no reset so a programmed sequence survives rst.
  logic [2:0] mem_color  [8];
  logic [3:0] mem_bright [8];
  logic [7:0] mem_dwell  [8];

  assign wr.wr_ready = (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (wr.wr_valid && wr.wr_ready) begin
      mem_color[wr.wr_addr]  <= wr.wr_color;
      mem_bright[wr.wr_addr] <= wr.wr_bright;
      mem_dwell[wr.wr_addr]  <= wr.wr_dwell;
    end
  end

  assign tick      = &presc_q;
  assign last_step = ({1'b0, step_q} == (len_q - 4'd1));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    len_d    = len_q;
    dwell_d  = dwell_q;
    presc_d  = presc_q;
    color_d  = color_q;
    bright_d = bright_q;
    unique case (state_q)
      StIdle: begin
        if (start && (len != 4'd0)) begin
          state_d = StFetch;
          step_d  = 3'd0;
          len_d   = (len > 4'd8) ? 4'd8 : len;
        end
      end
      StFetch: begin
        color_d  = mem_color[step_q];
        bright_d = mem_bright[step_q];
        dwell_d  = (mem_dwell[step_q] == 8'd0) ? 8'd1 : mem_dwell[step_q];
        presc_d  = '0;
        state_d  = StRun;
      end
      StRun: begin
        presc_d = presc_q + 1'b1;
        if (tick) begin
          if (dwell_q == 8'd1) begin
            if (!last_step) begin
              step_d  = step_q + 3'd1;
              state_d = StFetch;
            end else begin
`ifdef LED_SEQ_LOOP_EN
              step_d  = 3'd0;
              state_d = StFetch;
`else
              state_d = StDone;
`endif
            end
          end else begin
            dwell_d = dwell_q - 8'd1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort takes priority over start and over a step boundary.
    if (stop) state_d = StIdle;
  end

  assign led_on = (state_q == StRun) ? (color_q & {3{pwm_q < bright_q}}) : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      step_q   <= 3'd0;
      len_q    <= 4'd0;
      dwell_q  <= 8'd0;
      presc_q  <= '0;
      color_q  <= 3'd0;
      bright_q <= 4'd0;
      pwm_q    <= 4'd0;
      led_q    <= {3{ACTIVE_LOW}};
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      len_q    <= len_d;
      dwell_q  <= dwell_d;
      presc_q  <= presc_d;
      color_q  <= color_d;
      bright_q <= bright_d;
      pwm_q    <= pwm_q + 4'd1;
      led_q    <= led_on ^ {3{ACTIVE_LOW}};
    end
  end

  assign busy  = (state_q == StFetch) || (state_q == StRun);
  assign done  = (state_q == StDone);
  assign step  = step_q;
  assign led_r = led_q[2];
  assign led_g = led_q[1];
  assign led_b = led_q[0];

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: expected per-cycle timelines are built from entry
// contents (fetch cycle + dwell*4 run cycles per step) and compared every cycle.
module tb_led_sequencer;
  localparam int TICK = 4;  // 2**PRESCALE with PRESCALE=2
`ifdef LED_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] len = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy, done, led_r, led_g, led_b;
  logic [2:0] step;

  led_sequencer_if wr_if ();

  led_sequencer #(.PRESCALE(2), .ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr_if.slave),
    .len   (len),
    .start (start),
    .stop  (stop),
    .busy  (busy),
    .done  (done),
    .step  (step),
    .led_r (led_r),
    .led_g (led_g),
    .led_b (led_b)
  );

  always #5 clk = ~clk;

  // Free-running PWM phase as seen during the current cycle.
  int pwm_m = 0;
  always @(posedge clk) pwm_m <= rst ? 0 : (pwm_m + 1) % 16;

  int n_checks = 0;
  int n_fail = 0;

  logic [2:0] m_color  [8];
  logic [3:0] m_bright [8];
  int         m_dwell  [8];

  typedef struct {
    bit       busy;
    bit       done;
    bit       run;
    int       step;
    logic [2:0] color;
    logic [3:0] bright;
  } exp_t;

  exp_t       sched[$];
  exp_t       idle_e;
  logic [2:0] prev_on = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_cycle(input exp_t e);
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("wr_ready", 32'(wr_if.wr_ready), 32'(!e.busy && !e.done));
    if (e.busy) chk("step", 32'(step), 32'(e.step));
    chk("leds", 32'({led_r, led_g, led_b}), 32'(prev_on));
    prev_on = (e.run && (pwm_m < int'(e.bright))) ? e.color : 3'b000;
  endtask

  task automatic build(input int len_in);
    int   l;
    int   passes;
    exp_t e;
    l = (len_in > 8) ? 8 : len_in;
    passes = LOOP ? 2 : 1;
    sched.delete();
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < l; k++) begin
        e = idle_e;
        e.busy = 1'b1;
        e.step = k;
        sched.push_back(e);
        e.run = 1'b1;
        e.color = m_color[k];
        e.bright = m_bright[k];
        for (int r = 0; r < ((m_dwell[k] == 0) ? 1 : m_dwell[k]) * TICK; r++) sched.push_back(e);
      end
    end
    if (!LOOP) begin
      e = idle_e;
      e.done = 1'b1;
      sched.push_back(e);
      sched.push_back(idle_e);
    end
  endtask

  // kind 0: abort with stop, kind 1: abort with rst, at schedule index stop_at.
  task automatic play(input int stop_at, input bit kind);
    int sa;
    sa = (LOOP && stop_at < 0) ? sched.size() - 1 : stop_at;
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      check_cycle(sched[i]);
      if (sched[i].done) wr_if.wr_valid = 1'b0;
      if (i == sa) begin
        if (kind) rst = 1'b1;
        else stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        rst = 1'b0;
        wr_if.wr_valid = 1'b0;
        if (kind) prev_on = 3'b000;
        repeat (3) begin
          @(negedge clk);
          check_cycle(idle_e);
        end
        return;
      end
    end
  endtask

  task automatic start_seq(input logic [3:0] l);
    @(negedge clk);
    len = l;
    start = 1'b1;
    prev_on = 3'b000;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic write(input int a, input logic [2:0] c, input logic [3:0] b, input int d);
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr = 3'(a);
    wr_if.wr_color = c;
    wr_if.wr_bright = b;
    wr_if.wr_dwell = 8'(d);
    chk("wr_ready_idle", 32'(wr_if.wr_ready), 32'd1);
    @(posedge clk);
    #1;
    wr_if.wr_valid = 1'b0;
    m_color[a] = c;
    m_bright[a] = b;
    m_dwell[a] = d;
  endtask

  initial begin
    int l;
    idle_e = '{busy: 1'b0, done: 1'b0, run: 1'b0, step: 0, color: 3'b000, bright: 4'd0};
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr = 3'd0;
    wr_if.wr_color = 3'd0;
    wr_if.wr_bright = 4'd0;
    wr_if.wr_dwell = 8'd0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_cycle(idle_e);

    // Single red step at 15/16 duty for 8 run cycles.
    write(0, 3'b100, 4'd15, 2);
    for (int a = 1; a < 8; a++)
      write(a, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    start_seq(4'd1);
    build(1);
    play(-1, 1'b0);

    // Blue at 4/16 for one tick, then a dark three-tick step.
    write(0, 3'b001, 4'd4, 1);
    write(1, 3'b010, 4'd0, 3);
    start_seq(4'd2);
    build(2);
    play(-1, 1'b0);

    // Dwell 0 behaves as one tick.
    write(0, 3'b111, 4'd8, 0);
    start_seq(4'd1);
    build(1);
    play(-1, 1'b0);

    // Write and start in the same cycle: fetch sees the new entry.
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr = 3'd0;
    wr_if.wr_color = 3'b010;
    wr_if.wr_bright = 4'd15;
    wr_if.wr_dwell = 8'd1;
    len = 4'd1;
    start = 1'b1;
    prev_on = 3'b000;
    @(posedge clk);
    #1;
    wr_if.wr_valid = 1'b0;
    start = 1'b0;
    m_color[0] = 3'b010;
    m_bright[0] = 4'd15;
    m_dwell[0] = 1;
    build(1);
    play(-1, 1'b0);

    // stop together with start is ignored start.
    @(negedge clk);
    len = 4'd2;
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_cycle(idle_e);
    end

    // stop during step 1's run phase.
    start_seq(4'd3);
    build(3);
    play(6, 1'b0);

    // Writes during a run stall and must not land in memory.
    start_seq(4'd2);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr = 3'd0;
    wr_if.wr_color = 3'b101;
    wr_if.wr_bright = 4'd3;
    wr_if.wr_dwell = 8'd7;
    build(2);
    play(-1, 1'b0);
    wr_if.wr_valid = 1'b0;
    start_seq(4'd1);
    build(1);
    play(-1, 1'b0);

    // len=0 is ignored.
    start_seq(4'd0);
    repeat (3) begin
      @(negedge clk);
      check_cycle(idle_e);
    end

    // len=12 clamps to 8 steps.
    start_seq(4'd12);
    build(12);
    play(-1, 1'b0);

    // Randomized programs and lengths, sometimes aborted.
    for (int it = 0; it < 5; it++) begin
      for (int a = 0; a < 8; a++)
        write(a, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      l = $urandom_range(1, 12);
      start_seq(4'(l));
      build(l);
      if ($urandom_range(0, 2) == 0) play($urandom_range(0, sched.size() - 3), 1'b0);
      else play(-1, 1'b0);
    end

    // rst mid-run aborts; the program survives it.
    write(0, 3'b110, 4'd9, 2);
    write(1, 3'b011, 4'd12, 1);
    start_seq(4'd2);
    build(2);
    play(5, 1'b1);
    start_seq(4'd2);
    build(2);
    play(-1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 16, log2 of clk cycles per dwell tick.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1, which inverts led_r/led_g/led_b when 1.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_valid  input  1  program-entry write request.
REQ-006 SHALL have port wr_ready  output  1  write acceptance; high only in IDLE.
REQ-007 SHALL have port wr_addr  input  3  entry index 0..7.
REQ-008 SHALL have port wr_color  input  3  {r,g,b} enables.
REQ-009 SHALL have port wr_bright  input  4  PWM duty in 1/16 steps.
REQ-010 SHALL have port wr_dwell  input  8  entry duration in ticks.
REQ-011 SHALL have port len  input  4  step count, sampled on start.
REQ-012 SHALL have port start  input  1  begin sequence.
REQ-013 SHALL have port stop  input  1  abort sequence.
REQ-014 SHALL have ports busy (output, 1, high in FETCH/RUN), done (output, 1, one-cycle pulse), step (output, 3, current index).
REQ-015 SHALL have ports led_r, led_g, led_b  output  1 each  registered LED drives.

Function
REQ-016 SHALL store 8 entries {color, bright, dwell}; write occurs when wr_valid && wr_ready.
REQ-017 SHALL implement states IDLE, FETCH, RUN, DONE.
REQ-018 IDLE: start with len!=0 -> FETCH, step=0, latch len clamped to 8; start with len=0 ignored.
REQ-019 FETCH (one cycle): load entry[step], dwell counter = max(dwell,1), clear prescaler -> RUN.
REQ-020 Prescaler: PRESCALE-bit counter; tick when all ones; counts only in RUN.
REQ-021 RUN: tick decrements dwell counter; tick with counter==1 ends step, so each step lasts exactly max(dwell,1)*2^PRESCALE cycles in RUN.
REQ-022 Step end with step<len-1 -> step+1, FETCH; with step==len-1 -> DONE.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE.
REQ-024 PWM: free-running 4-bit counter; channel on when color bit set and pwm_cnt < bright; bright=0 never on, bright=15 on 15/16.
REQ-025 LED outputs SHALL be off (pre-polarity) outside RUN; output = on XOR ACTIVE_LOW, registered one cycle.
REQ-026 stop SHALL win over start and over step end; any state -> IDLE next cycle, no done pulse.
REQ-027 Write and start in the same IDLE cycle: write commits first; FETCH reads the updated entry.
REQ-028 wr_valid outside IDLE SHALL stall (wr_ready=0), memory unchanged.
REQ-029 Latency: start at cycle N -> FETCH N+1 -> RUN N+2 -> LEDs reflect entry 0 from N+3.

Reset
REQ-030 rst SHALL force IDLE, step=0, busy=0, done=0, prescaler=0, pwm_cnt=0, LEDs off (led_*=ACTIVE_LOW), wr_ready=1 next cycle.
REQ-031 rst SHALL NOT clear program memory; rst mid-RUN aborts with no done pulse.

Configuration
REQ-032 With LED_SEQ_LOOP_EN defined, step end at step==len-1 SHALL go to FETCH with step=0 (endless; only stop/rst exits; done never pulses).
REQ-033 Without LED_SEQ_LOOP_EN, REQ-022 one-shot behaviour SHALL apply.

Verification (PRESCALE=2, ACTIVE_LOW=0)
REQ-034 Write entry0 {3'b100,15,2}, len=1, start -> led_r on 15/16 of cycles for 8 RUN cycles, done pulse once, busy low after.
REQ-035 Entries 0 {001,4,1}, 1 {010,0,3}; len=2 -> led_b duty 4/16 for 4 cycles, then all LEDs off 12 cycles, step 0 -> 1.
REQ-036 Entry dwell=0 -> step lasts 4 cycles (treated as 1).
REQ-037 stop asserted with start, and stop mid-RUN -> IDLE next cycle, LEDs off, no done.
REQ-038 wr_valid during RUN -> wr_ready=0, memory unchanged; len=0 start -> stays IDLE; len=12 -> 8 steps.
REQ-039 LED_SEQ_LOOP_EN defined, len=2 -> step sequence 0,1,0,1,... with no done; rst mid-RUN -> IDLE, memory retained.
